// File: rtl/uart_receiver.sv
// uart_receiver: recovers one UART frame (start, LSB-first payload, stop) and presents it in parallel
//   clk, rst            : clock, async active-high reset
//   rx                  : serial line, idle high, asynchronous
//   msg_select          : 0 raw MSG_SIZE-bit payload, 1 coded CODED_MSG_SIZE-bit payload
//   baud_select         : 0 1200 baud, 1 2400 baud
//   rx_data, rx_coded   : last good payload (zero-extended) and its msg_select
//   data_valid          : 1-cycle pulse when rx_data/rx_coded update
//   frame_error         : 1-cycle pulse when the stop bit is sampled low
module uart_receiver #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD_RATE_2400 = 2400,
  parameter int BAUD_RATE_1200 = 1200,
  parameter int MSG_SIZE = 6,
  parameter int STEP = 0,
  localparam int CODED_MSG_SIZE = 2 * (MSG_SIZE + 2 * (2 * STEP + 1))
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic msg_select,
  input  logic baud_select,
  output logic [CODED_MSG_SIZE-1:0] rx_data,
  output logic rx_coded,
  output logic data_valid,
  output logic frame_error
);
  localparam logic [31:0] TPB_FAST = 32'(CLK_FREQ / BAUD_RATE_2400);
  localparam logic [31:0] TPB_SLOW = 32'(CLK_FREQ / BAUD_RATE_1200);
  localparam int IW = $clog2(CODED_MSG_SIZE + 1);
  localparam logic [CODED_MSG_SIZE:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic rx_meta, rxs, sample, last_bit, coded_q;
  logic [31:0] tick_cnt, tpb, limit;
  logic [IW-1:0] bit_idx, len;
  logic [CODED_MSG_SIZE-1:0] shift, mask;
  // the start bit is checked at its middle, so every later sample lands mid-bit
  assign limit = state == START ? tpb >> 1 : tpb;
  assign sample = tick_cnt == limit - 32'd1;
  assign last_bit = bit_idx == len - IW'(1);
  assign mask = CODED_MSG_SIZE'((ONE << len) - ONE);
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = rxs ? IDLE : START;
      START:   state_n = !sample ? START : rxs ? IDLE : DATA;
      DATA:    state_n = sample && last_bit ? STOP : DATA;
      STOP:    state_n = !sample ? STOP : rxs ? IDLE : BRK;
      BRK:     state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      tick_cnt <= '0;
      tpb <= '0;
      len <= '0;
      bit_idx <= '0;
      shift <= '0;
      coded_q <= 1'b0;
      rx_data <= '0;
      rx_coded <= 1'b0;
      data_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs <= rx_meta;
      data_valid <= state == STOP && sample && rxs;
      frame_error <= state == STOP && sample && !rxs;
      tick_cnt <= (state inside {START, DATA, STOP}) && !sample ? tick_cnt + 32'd1 : '0;
      if (state == IDLE && !rxs) begin
        tpb <= baud_select ? TPB_FAST : TPB_SLOW;
        len <= msg_select ? IW'(CODED_MSG_SIZE) : IW'(MSG_SIZE);
        coded_q <= msg_select;
      end
      if (state == START && sample) begin
        bit_idx <= '0;
        shift <= '0;
      end
      if (state == DATA && sample) begin
        shift <= shift | (CODED_MSG_SIZE'(rxs) << bit_idx);
        bit_idx <= bit_idx + IW'(1);
      end
      if (state == STOP && sample && rxs) begin
        rx_data <= shift & mask;
        rx_coded <= coded_q;
      end
    end
  end
endmodule
